if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage that produces the `{pc, inst}` pair consumed by the IF/ID pipeline register. It owns the fetch PC, issues word reads to the synchronous base-RAM instruction port, and holds each returned instruction until ID accepts it. It redirects on taken jumps/branches and defers fetches while a data access owns base RAM. It sits between the PC/branch logic and the IF/ID register, driving `ctl_if_over` to it.

## Interface
- `RESET_PC`, default 32'h8000_0000: fetch address of the first instruction after reset; must be word aligned.
- `clk_i` in 1: sole clock; all state changes on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `ctl_id_allow_in_i` in 1: ID can accept an instruction this cycle.
- `ctl_jbr_taken_i` in 1: taken jump/branch resolved in ID this cycle.
- `jbr_target_i` in 32: redirect byte address; bits [1:0] ignored (treated as 00).
- `ctl_baseram_hazard` in 1: base RAM is used by a data access this cycle; no fetch may be issued.
- `inst_sram_en_o` out 1: read request to instruction RAM this cycle.
- `inst_sram_addr_o` out 32: byte address of the request, word aligned.
- `inst_sram_rdata_i` in 32: read data, valid exactly one cycle after the request cycle.
- `if_pc_o` out 32: PC of the presented instruction.
- `if_inst_o` out 32: presented instruction word.
- `ctl_if_over_o` out 1: `if_pc_o`/`if_inst_o` are valid this cycle.

## Operation
- State: `fetch_pc` (next address to request), `pc_r` (PC of the in-flight or held instruction), `inst_buf` (held word), 3-state FSM REQ / RESP / HOLD.
- accept = `ctl_if_over_o` & `ctl_id_allow_in_i` & !`ctl_jbr_taken_i` & !`ctl_baseram_hazard`. An instruction is consumed only on accept. IF/ID does not latch in hazard or redirect cycles.
- REQ: `inst_sram_addr_o` = `fetch_pc`; `ctl_if_over_o` = 0.
  - Redirect has priority: `fetch_pc` <= {target[31:2], 2'b00}; `en` = 0; stay in REQ.
  - Else if hazard: `en` = 0; stay in REQ.
  - Else: `en` = 1; `pc_r` <= `fetch_pc`; go to RESP.
- RESP: `en` = 0; `if_inst_o` = `inst_sram_rdata_i`; `if_pc_o` = `pc_r`; `ctl_if_over_o` = !`ctl_jbr_taken_i`.
  - Redirect: discard data; `fetch_pc` <= target; go to REQ.
  - Else if accept: `fetch_pc` <= `pc_r` + 4; go to REQ.
  - Else: `inst_buf` <= rdata; go to HOLD.
- HOLD: `en` = 0; `if_inst_o` = `inst_buf`; `if_pc_o` = `pc_r`; `ctl_if_over_o` = !`ctl_jbr_taken_i`.
  - Redirect: `fetch_pc` <= target; go to REQ.
  - Else if accept: `fetch_pc` <= `pc_r` + 4; go to REQ.
  - Else: stay in HOLD.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Hazard in RESP/HOLD does not disturb the held instruction. It only blocks the accept.

## Timing
- Reset values: FSM = REQ; `fetch_pc` = `RESET_PC`; `pc_r` = 0; `inst_buf` = 0; `ctl_if_over_o` = 0; `if_pc_o` = 0; `if_inst_o` = 0; `inst_sram_en_o` = 0 while `rst_i` is high.
- `rst_i` asserted in any state returns to reset values on the next edge. A response in flight is discarded.
- First request: the first cycle with `rst_i` low and no hazard, addr = `RESET_PC`. Its instruction is presented the next cycle.
- Peak throughput: one instruction per 2 cycles (REQ, RESP with accept).
- Redirect-to-request latency: target is requested in the cycle after the redirect, if there is no hazard.
- `inst_sram_en_o`, `inst_sram_addr_o`, and `ctl_if_over_o` are combinational from state plus the hazard/redirect inputs. All other state is registered.
- Simultaneous redirect and allow_in: redirect wins; no instruction is consumed.

## Test plan
- Reset release, no stalls, `ctl_id_allow_in_i` = 1 -> requests at 0x8000_0000, 0x8000_0004, 0x8000_0008 on alternating cycles. Each RESP cycle presents the matching pc/inst with over = 1.
- allow_in held low for 3 cycles after the RESP presenting 0x8000_0004 -> HOLD keeps pc = 0x8000_0004 and inst stable, no requests issued. On release, the next request is 0x8000_0008.
- Redirect in RESP with target 0x8000_0102 -> over = 0 that cycle, data dropped, next request at 0x8000_0100.
- `ctl_baseram_hazard` high for 4 cycles in REQ -> `en` = 0 throughout, then a request at the unchanged `fetch_pc`. Hazard during HOLD -> no accept even with allow_in = 1.
- Redirect to 0xFFFF_FFFC, then accept -> next request at 0x0000_0000.
- `rst_i` pulsed while in HOLD -> next cycle all outputs are 0, then a request at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads to base RAM and
// holds the returned instruction until ID takes it.
//
// state  | meaning
// S_REQ  | fetch_pc may be requested this cycle
// S_RESP | read data arrives this cycle and is presented to ID
// S_HOLD | ID has not taken the word yet; it is replayed from inst_buf
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ctl_id_allow_in_i,
   input  logic        ctl_jbr_taken_i,
   input  logic [31:0] jbr_target_i,
   input  logic        ctl_baseram_hazard,
   output logic        inst_sram_en_o,
   output logic [31:0] inst_sram_addr_o,
   input  logic [31:0] inst_sram_rdata_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        ctl_if_over_o
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_RESP = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_pc;
   logic [31:0] r_inst_buf;

   logic [31:0] w_target;
   logic        w_accept;
   logic        w_unused_target_bits;

   assign w_target             = {jbr_target_i[31:2], 2'b00};
   assign w_unused_target_bits = ^jbr_target_i[1:0];

   always_comb begin
      inst_sram_en_o   = 1'b0;
      inst_sram_addr_o = r_fetch_pc;
      if_pc_o          = r_pc;
      if_inst_o        = r_inst_buf;
      ctl_if_over_o    = 1'b0;
      case (r_state)
         S_REQ: begin
            inst_sram_en_o = !rst_i && !ctl_jbr_taken_i && !ctl_baseram_hazard;
         end
         S_RESP: begin
            if_inst_o     = inst_sram_rdata_i;
            ctl_if_over_o = !ctl_jbr_taken_i;
         end
         S_HOLD: begin
            ctl_if_over_o = !ctl_jbr_taken_i;
         end
         default: begin
            ctl_if_over_o = 1'b0;
         end
      endcase
   end

   // Hazard and redirect both veto consumption; IF/ID does not latch then.
   assign w_accept = ctl_if_over_o && ctl_id_allow_in_i &&
                     !ctl_jbr_taken_i && !ctl_baseram_hazard;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_REQ;
         r_fetch_pc <= RESET_PC;
         r_pc       <= 32'h0;
         r_inst_buf <= 32'h0;
      end else begin
         case (r_state)
            S_REQ: begin
               if (ctl_jbr_taken_i) begin
                  r_fetch_pc <= w_target;
               end else if (!ctl_baseram_hazard) begin
                  r_pc    <= r_fetch_pc;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (ctl_jbr_taken_i) begin
                  r_fetch_pc <= w_target;
                  r_state    <= S_REQ;
               end else if (w_accept) begin
                  r_fetch_pc <= r_pc + 32'd4;
                  r_state    <= S_REQ;
               end else begin
                  r_inst_buf <= inst_sram_rdata_i;
                  r_state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (ctl_jbr_taken_i) begin
                  r_fetch_pc <= w_target;
                  r_state    <= S_REQ;
               end else if (w_accept) begin
                  r_fetch_pc <= r_pc + 32'd4;
                  r_state    <= S_REQ;
               end
            end
            default: begin
               r_state <= S_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a one-cycle-latency RAM model returns an
// address-derived word so every presented instruction can be predicted.
module tb_if_fetch;

   logic        clk_i;
   logic        rst_i;
   logic        ctl_id_allow_in_i;
   logic        ctl_jbr_taken_i;
   logic [31:0] jbr_target_i;
   logic        ctl_baseram_hazard;
   logic        inst_sram_en_o;
   logic [31:0] inst_sram_addr_o;
   logic [31:0] inst_sram_rdata_i;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        ctl_if_over_o;

   int checks   = 0;
   int failures = 0;

   if_fetch #(.RESET_PC(32'h8000_0000)) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .ctl_id_allow_in_i  (ctl_id_allow_in_i),
      .ctl_jbr_taken_i    (ctl_jbr_taken_i),
      .jbr_target_i       (jbr_target_i),
      .ctl_baseram_hazard (ctl_baseram_hazard),
      .inst_sram_en_o     (inst_sram_en_o),
      .inst_sram_addr_o   (inst_sram_addr_o),
      .inst_sram_rdata_i  (inst_sram_rdata_i),
      .if_pc_o            (if_pc_o),
      .if_inst_o          (if_inst_o),
      .ctl_if_over_o      (ctl_if_over_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Non-requested cycles return garbage so stale data would be visible.
   initial inst_sram_rdata_i = 32'h0;
   always @(posedge clk_i) begin
      if (inst_sram_en_o) inst_sram_rdata_i <= mem_word(inst_sram_addr_o);
      else                inst_sram_rdata_i <= 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_req(input string tag, input logic [31:0] addr);
      chk({tag, "_en"}, {31'h0, inst_sram_en_o}, 32'h1);
      chk({tag, "_addr"}, inst_sram_addr_o, addr);
      chk({tag, "_over"}, {31'h0, ctl_if_over_o}, 32'h0);
   endtask

   task automatic chk_pres(input string tag, input logic [31:0] pc);
      chk({tag, "_en"}, {31'h0, inst_sram_en_o}, 32'h0);
      chk({tag, "_over"}, {31'h0, ctl_if_over_o}, 32'h1);
      chk({tag, "_pc"}, if_pc_o, pc);
      chk({tag, "_inst"}, if_inst_o, mem_word(pc));
   endtask

   initial begin
      rst_i = 1'b1;
      ctl_id_allow_in_i = 1'b1;
      ctl_jbr_taken_i = 1'b0;
      jbr_target_i = 32'h0;
      ctl_baseram_hazard = 1'b0;
      tick();
      tick();

      chk("rst_over", {31'h0, ctl_if_over_o}, 32'h0);
      chk("rst_pc", if_pc_o, 32'h0);
      chk("rst_inst", if_inst_o, 32'h0);
      chk("rst_en", {31'h0, inst_sram_en_o}, 32'h0);

      // streaming at full rate
      rst_i = 1'b0; settle();
      chk_req("req0", 32'h8000_0000); tick();
      chk_pres("resp0", 32'h8000_0000); tick();
      chk_req("req1", 32'h8000_0004); tick();

      // ID stalls for 3 cycles starting at the RESP of 0x8000_0004
      ctl_id_allow_in_i = 1'b0; settle();
      chk_pres("resp1", 32'h8000_0004); tick();
      chk_pres("hold1a", 32'h8000_0004); tick();
      chk_pres("hold1b", 32'h8000_0004); tick();
      ctl_id_allow_in_i = 1'b1; settle();
      chk_pres("hold1c", 32'h8000_0004); tick();
      chk_req("req2", 32'h8000_0008); tick();

      // redirect during RESP drops the data, low bits of target ignored
      ctl_jbr_taken_i = 1'b1; jbr_target_i = 32'h8000_0102; settle();
      chk("resp2_redir_over", {31'h0, ctl_if_over_o}, 32'h0);
      chk("resp2_redir_en", {31'h0, inst_sram_en_o}, 32'h0);
      tick();
      ctl_jbr_taken_i = 1'b0;

      // hazard for 4 cycles in REQ
      ctl_baseram_hazard = 1'b1; settle();
      for (int i = 0; i < 4; i++) begin
         chk("haz_req_en", {31'h0, inst_sram_en_o}, 32'h0);
         chk("haz_req_addr", inst_sram_addr_o, 32'h8000_0100);
         tick();
      end
      ctl_baseram_hazard = 1'b0; settle();
      chk_req("req3", 32'h8000_0100); tick();

      ctl_id_allow_in_i = 1'b0; settle();
      chk_pres("resp3", 32'h8000_0100); tick();

      // hazard in HOLD blocks the accept even with allow_in
      ctl_id_allow_in_i = 1'b1; ctl_baseram_hazard = 1'b1; settle();
      chk_pres("hold3_haz", 32'h8000_0100); tick();
      ctl_baseram_hazard = 1'b0; settle();
      chk_pres("hold3_after_haz", 32'h8000_0100); tick();
      settle();
      chk_req("req4", 32'h8000_0104);

      // redirect in REQ to the top word, then wrap
      ctl_jbr_taken_i = 1'b1; jbr_target_i = 32'hFFFF_FFFE; settle();
      chk("req4_redir_en", {31'h0, inst_sram_en_o}, 32'h0);
      tick();
      ctl_jbr_taken_i = 1'b0; settle();
      chk_req("req_top", 32'hFFFF_FFFC); tick();
      chk_pres("resp_top", 32'hFFFF_FFFC); tick();
      chk_req("req_wrap", 32'h0000_0000); tick();

      // reset while holding
      ctl_id_allow_in_i = 1'b0; settle();
      chk_pres("resp_wrap", 32'h0000_0000); tick();
      chk_pres("hold_wrap", 32'h0000_0000);
      rst_i = 1'b1; tick();
      chk("rst2_over", {31'h0, ctl_if_over_o}, 32'h0);
      chk("rst2_pc", if_pc_o, 32'h0);
      chk("rst2_inst", if_inst_o, 32'h0);
      chk("rst2_en", {31'h0, inst_sram_en_o}, 32'h0);
      rst_i = 1'b0; ctl_id_allow_in_i = 1'b1; settle();
      chk_req("req_after_rst", 32'h8000_0000); tick();
      chk_pres("resp_after_rst", 32'h8000_0000); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
